alu_arbiter: RTL and testbench

Shares one combinational ALU (8-bit Rs1/Rs2, 4-bit Opcode, Out, Carry; ops ADD..DIV, codes 0-9) between two requesters. Each requester issues an operation through a valid/ready handshake. The block grants one requester round-robin, registers the operands onto the ALU, captures Out/Carry, and returns the result with the requester id under valid/ready backpressure. Only one operation is outstanding at a time; the block sits between the issue logic and the ALU instance.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/rr_arb2.sv | 33 +++
 rtl/alu_arbiter.sv | 162 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the ALU arbiter slice.
//   WIDTH/OPW/NUM_OPS : default operand width, opcode width, legal opcode count
//   OP_*              : ALU opcode encodings (ADD=0 .. DIV=9)
//   ST_*              : arbiter FSM state encodings
package alu_pkg;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned OPW     = 4;
  localparam int unsigned NUM_OPS = 10;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_DIV = 4'd9;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant.
//   clk, rst    : clock, synchronous active-high reset (pointer -> 0)
//   req_valid   : per-requester request
//   en          : grants may be issued this cycle
//   gnt         : one-hot grant (combinational); a grant is an accept
//   gnt_id      : index of the favoured/granted requester
//   accept      : a grant was issued this cycle
// The pointer moves past the granted requester only when a grant happens.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_valid,
  input  logic       en,
  output logic [1:0] gnt,
  output logic       gnt_id,
  output logic       accept
);

  logic rr_ptr_q, rr_ptr_d;

  always_comb begin
    gnt_id   = req_valid[rr_ptr_q] ? rr_ptr_q : ~rr_ptr_q;
    gnt      = (en && req_valid[gnt_id]) ? (2'b01 << gnt_id) : 2'b00;
    accept   = |gnt;
    rr_ptr_d = accept ? ~gnt_id : rr_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) rr_ptr_q <= 1'b0;
    else     rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
//   clk, rst               : clock, synchronous active-high reset
//   req_valid/req_ready    : per-requester issue handshake (bit i = requester i)
//   req_rs1/req_rs2/req_op : packed per-requester operands and opcode
//   alu_rs1/alu_rs2/alu_opcode : registered ALU inputs
//   alu_out/alu_carry      : ALU result
//   rsp_valid/rsp_ready    : response handshake
//   rsp_id/rsp_data/rsp_carry/rsp_err : response fields
// Optional macro ALU_OP_CHECK_EN: flags illegal opcodes and divide-by-zero,
// returning rsp_err=1 with zero data; otherwise rsp_err is tied low.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = alu_pkg::WIDTH,
  parameter int unsigned OPW     = alu_pkg::OPW,
  parameter int unsigned NUM_OPS = alu_pkg::NUM_OPS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*WIDTH-1:0] req_rs1,
  input  logic [2*WIDTH-1:0] req_rs2,
  input  logic [2*OPW-1:0]   req_op,
  output logic [WIDTH-1:0]   alu_rs1,
  output logic [WIDTH-1:0]   alu_rs2,
  output logic [OPW-1:0]     alu_opcode,
  input  logic [WIDTH-1:0]   alu_out,
  input  logic               alu_carry,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [WIDTH-1:0]   rsp_data,
  output logic               rsp_carry,
  output logic               rsp_err
);

  if (NUM_OPS > (1 << OPW)) begin : g_cfg_err
    $error("NUM_OPS exceeds the opcode space");
  end

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] alu_rs1_q, alu_rs1_d, alu_rs2_q, alu_rs2_d;
  logic [OPW-1:0]   alu_op_q, alu_op_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             carry_q, carry_d;

  logic [1:0]       gnt;
  logic             gnt_id, accept;
  logic [WIDTH-1:0] sel_rs1, sel_rs2;
  logic [OPW-1:0]   sel_op;

  // Gating with rst keeps req_ready low while reset is held.
  rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .en        ((state_q == ST_IDLE) && !rst),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .accept    (accept)
  );

  assign sel_rs1 = gnt_id ? req_rs1[2*WIDTH-1:WIDTH] : req_rs1[WIDTH-1:0];
  assign sel_rs2 = gnt_id ? req_rs2[2*WIDTH-1:WIDTH] : req_rs2[WIDTH-1:0];
  assign sel_op  = gnt_id ? req_op[2*OPW-1:OPW]      : req_op[OPW-1:0];

`ifdef ALU_OP_CHECK_EN
  logic err_q, err_d;
  logic bad_op;
  assign bad_op = (32'(sel_op) >= NUM_OPS) ||
                  ((sel_op == OPW'(OP_DIV)) && (sel_rs2 == '0));
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    alu_rs1_d = alu_rs1_q;
    alu_rs2_d = alu_rs2_q;
    alu_op_d  = alu_op_q;
    id_d      = id_q;
    data_d    = data_q;
    carry_d   = carry_q;
`ifdef ALU_OP_CHECK_EN
    err_d     = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          alu_rs1_d = sel_rs1;
          alu_rs2_d = sel_rs2;
          alu_op_d  = sel_op;
          id_d      = gnt_id;
          state_d   = ST_EXEC;
`ifdef ALU_OP_CHECK_EN
          err_d     = bad_op;
          // Flagged ops still occupy the ALU slot, but with a harmless ADD 0+0.
          if (bad_op) begin
            alu_rs1_d = '0;
            alu_rs2_d = '0;
            alu_op_d  = '0;
          end
`endif
        end
      end
      ST_EXEC: begin
        data_d  = alu_out;
        carry_d = alu_carry;
`ifdef ALU_OP_CHECK_EN
        if (err_q) begin
          data_d  = '0;
          carry_d = 1'b0;
        end
`endif
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      alu_rs1_q <= '0;
      alu_rs2_q <= '0;
      alu_op_q  <= '0;
      id_q      <= 1'b0;
      data_q    <= '0;
      carry_q   <= 1'b0;
`ifdef ALU_OP_CHECK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      alu_rs1_q <= alu_rs1_d;
      alu_rs2_q <= alu_rs2_d;
      alu_op_q  <= alu_op_d;
      id_q      <= id_d;
      data_q    <= data_d;
      carry_q   <= carry_d;
`ifdef ALU_OP_CHECK_EN
      err_q     <= err_d;
`endif
    end
  end

  assign req_ready  = gnt;
  assign alu_rs1    = alu_rs1_q;
  assign alu_rs2    = alu_rs2_q;
  assign alu_opcode = alu_op_q;
  assign rsp_valid  = (state_q == ST_RESP);
  assign rsp_id     = id_q;
  assign rsp_data   = data_q;
  assign rsp_carry  = carry_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed bench for alu_arbiter with a behavioural ALU.
// Expected responses are queued at issue time; a monitor pops and compares
// each accepted response.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [15:0] req_rs1 = '0, req_rs2 = '0;
  logic [7:0]  req_op = '0;
  logic [7:0]  alu_rs1, alu_rs2, alu_out;
  logic [3:0]  alu_opcode;
  logic        alu_carry;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_id, rsp_carry, rsp_err;
  logic [7:0]  rsp_data;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(8), .OPW(4), .NUM_OPS(10)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_op(req_op),
    .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_opcode(alu_opcode),
    .alu_out(alu_out), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_err(rsp_err)
  );

  // Behavioural ALU; unimplemented codes return 8'hEE so pass-through is visible.
  always_comb begin
    alu_carry = 1'b0;
    alu_out   = 8'hEE;
    case (alu_opcode)
      OP_ADD: {alu_carry, alu_out} = {1'b0, alu_rs1} + {1'b0, alu_rs2};
      OP_SUB: {alu_carry, alu_out} = {1'b0, alu_rs1} - {1'b0, alu_rs2};
      OP_AND: alu_out = alu_rs1 & alu_rs2;
      OP_XOR: alu_out = alu_rs1 ^ alu_rs2;
      OP_DIV: begin
        if (alu_rs2 == '0) begin
          alu_out   = 8'hFF;
          alu_carry = 1'b1;
        end else begin
          alu_out = alu_rs1 / alu_rs2;
        end
      end
      default: ;
    endcase
  end

  typedef struct packed {
    logic       id;
    logic [7:0] data;
    logic       carry;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail(input string name);
    n_checks++;
    $display("FAIL %s: timeout/unexpected event", name);
  endtask

  task automatic push(input logic id, input logic [7:0] d, input logic c, input logic e);
    exp_t x;
    x.id = id; x.data = d; x.carry = c; x.err = e;
    exp_q.push_back(x);
  endtask

  // Monitor: sample mid-low-phase, after the driver's negedge updates.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          fail("unexpected_rsp");
        end else begin
          e = exp_q.pop_front();
          check("rsp{id,carry,err,data}", 32'({rsp_id, rsp_carry, rsp_err, rsp_data}),
                32'({e.id, e.carry, e.err, e.data}));
        end
      end
    end
  end

  // Call at a negedge; returns at the negedge after the accepting posedge.
  task automatic issue(input int id, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] op, input logic [7:0] ed, input logic ec,
                       input logic ee);
    int n;
    push(id[0], ed, ec, ee);
    req_rs1[id*8 +: 8] = a;
    req_rs2[id*8 +: 8] = b;
    req_op[id*4 +: 4]  = op;
    req_valid[id]      = 1'b1;
    n = 0;
    #1;
    while (!req_ready[id] && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 50) fail("issue_wait_ready");
    @(posedge clk);
    @(negedge clk);
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) fail("drain");
    @(negedge clk);
  endtask

  initial begin
    int n;
    int grants;
    logic [1:0] exp_gnt;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_outputs",
          32'({req_ready, rsp_valid, rsp_id, rsp_carry, rsp_err}), 32'(0));
    check("reset_alu_rsp", 32'({alu_rs1, alu_rs2, alu_opcode, rsp_data}), 32'(0));
    @(negedge clk);

    // 1: single ADD, latency N+2
    issue(0, 8'h0F, 8'h01, OP_ADD, 8'h10, 1'b0, 1'b0);
    #1;
    check("lat_exec_no_valid", 32'(rsp_valid), 32'(0));
    check("alu_regs_add", 32'({alu_rs1, alu_rs2, alu_opcode}), 32'({8'h0F, 8'h01, OP_ADD}));
    @(negedge clk);
    #1;
    check("lat_n2_valid", 32'(rsp_valid), 32'(1));
    wait_drain();

    // 6: ADD overflow
    issue(1, 8'hFF, 8'h01, OP_ADD, 8'h00, 1'b1, 1'b0);
    wait_drain();

    // 5: illegal opcode, divide by zero, legal divide
`ifdef ALU_OP_CHECK_EN
    issue(0, 8'h12, 8'h34, 4'hC, 8'h00, 1'b0, 1'b1);
    #1;
    check("alu_in_bad_op", 32'({alu_rs1, alu_rs2, alu_opcode}), 32'(0));
    wait_drain();
    issue(1, 8'h12, 8'h00, OP_DIV, 8'h00, 1'b0, 1'b1);
    wait_drain();
`else
    issue(0, 8'h12, 8'h34, 4'hC, 8'hEE, 1'b0, 1'b0);
    #1;
    check("alu_in_bad_op", 32'({alu_rs1, alu_rs2, alu_opcode}), 32'({8'h12, 8'h34, 4'hC}));
    wait_drain();
    issue(1, 8'h12, 8'h00, OP_DIV, 8'hFF, 1'b1, 1'b0);
    wait_drain();
`endif
    issue(0, 8'h10, 8'h04, OP_DIV, 8'h04, 1'b0, 1'b0);
    wait_drain();

    // 3: backpressure in RESP, blocked second requester
    rsp_ready = 1'b0;
    issue(0, 8'h0F, 8'h01, OP_ADD, 8'h10, 1'b0, 1'b0);
    push(1'b1, 8'h0E, 1'b0, 1'b0);
    req_rs1[15:8] = 8'h0F; req_rs2[15:8] = 8'h01; req_op[7:4] = OP_XOR;
    req_valid[1] = 1'b1;
    n = 0;
    while (!rsp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (n >= 10) fail("bp_wait_valid");
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_hold", 32'({rsp_valid, req_ready, rsp_id, rsp_carry, rsp_err, rsp_data}),
            32'({1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 8'h10}));
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_release_no_grant", 32'(req_ready), 32'(0));
    @(negedge clk);
    #1;
    check("bp_next_grant", 32'(req_ready), 32'(2'b10));
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    wait_drain();

    // 4: reset during EXEC discards the op
    req_rs1[7:0] = 8'h0F; req_rs2[7:0] = 8'h01; req_op[3:0] = OP_ADD;
    req_valid[0] = 1'b1;
    #1;
    check("rst_pre_grant", 32'(req_ready), 32'(2'b01));
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid_outputs",
          32'({req_ready, rsp_valid, rsp_id, rsp_carry, rsp_err}), 32'(0));
    check("rst_mid_alu_rsp", 32'({alu_rs1, alu_rs2, alu_opcode, rsp_data}), 32'(0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("rst_no_rsp", 32'(rsp_valid), 32'(0));
    end
    @(negedge clk);

    // 2: contention; pointer back at 0 after reset, grants alternate 0,1,0,1
    req_rs1 = {8'h0F, 8'h0F};
    req_rs2 = {8'h01, 8'h01};
    req_op  = {OP_AND, OP_SUB};
    push(1'b0, 8'h0E, 1'b0, 1'b0);
    push(1'b1, 8'h01, 1'b0, 1'b0);
    push(1'b0, 8'h0E, 1'b0, 1'b0);
    push(1'b1, 8'h01, 1'b0, 1'b0);
    req_valid = 2'b11;
    grants = 0;
    n = 0;
    while (grants < 4 && n < 40) begin
      #1;
      if (req_ready != 2'b00) begin
        exp_gnt = grants[0] ? 2'b10 : 2'b01;
        check("contend_grant", 32'(req_ready), 32'(exp_gnt));
        grants++;
      end
      @(negedge clk);
      n++;
    end
    if (n >= 40) fail("contend_timeout");
    req_valid = 2'b00;
    wait_drain();

    check("queue_empty", 32'(exp_q.size()), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
